// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: instruction fetch and data load/store share one
// 16-bit memory port, alternating on ties, with optional wait states per access.
module mem_arbiter #(
    parameter int WAIT_STATES = 0
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        f_req,
    input  logic [15:0] f_addr,
    output logic        f_ack,
    output logic [15:0] f_data,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic        d_byte,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_ack,
    output logic [15:0] d_rdata,
    output logic        err,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_wr_lb,
    output logic        mem_wr_ub,
    input  logic [15:0] mem_rdata,
    output logic        busy
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_last_data;   // 1 when the most recent grant went to the data port
    logic        r_is_data;
    logic        r_wr;
    logic        r_byte;
    logic        r_first;
    logic        r_err;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_f_data;
    logic [15:0] r_d_rdata;

    logic        w_accept;
    logic        w_grant_data;
    logic        w_misaligned;
    logic        w_finish;
    logic [7:0]  w_lane;
    logic [15:0] w_load_data;

    assign w_accept     = (r_state == IDLE) && (f_req || d_req);
    assign w_grant_data = d_req && (!f_req || !r_last_data);
    // r_byte is only ever set for data accesses, so fetches count as word accesses
    assign w_misaligned = r_addr[0] && !r_byte;
    assign w_finish     = (r_state == ACCESS) && (r_cnt == 4'd0);
    assign w_lane       = r_addr[0] ? mem_rdata[15:8] : mem_rdata[7:0];
    assign w_load_data  = w_misaligned ? 16'h0000 :
                          (r_byte ? {8'h00, w_lane} : mem_rdata);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        busy         = 1'b0;
        f_ack        = 1'b0;
        d_ack        = 1'b0;
        err          = 1'b0;
        mem_addr     = 16'h0000;
        mem_wdata    = 16'h0000;
        mem_wr_lb    = 1'b0;
        mem_wr_ub    = 1'b0;
        case (r_state)
            IDLE: begin
                if (f_req || d_req) begin
                    w_state_next = ACCESS;
                    w_cnt_next   = WAIT_CNT;
                end
            end
            ACCESS: begin
                busy      = 1'b1;
                mem_addr  = {r_addr[15:1], 1'b0};
                mem_wdata = r_wdata;
                if (r_first && r_wr && !w_misaligned) begin
                    mem_wr_lb = !r_byte || !r_addr[0];
                    mem_wr_ub = !r_byte || r_addr[0];
                end
                if (r_cnt == 4'd0) begin
                    w_state_next = DONE;
                end else begin
                    w_cnt_next = r_cnt - 4'd1;
                end
            end
            DONE: begin
                busy         = 1'b1;
                f_ack        = !r_is_data;
                d_ack        = r_is_data;
                err          = r_err;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            r_last_data <= 1'b0;
            r_is_data   <= 1'b0;
            r_wr        <= 1'b0;
            r_byte      <= 1'b0;
            r_first     <= 1'b0;
            r_err       <= 1'b0;
            r_addr      <= 16'h0000;
            r_wdata     <= 16'h0000;
            r_f_data    <= 16'h0000;
            r_d_rdata   <= 16'h0000;
        end else begin
            if (w_accept) begin
                r_is_data   <= w_grant_data;
                r_last_data <= w_grant_data;
                r_addr      <= w_grant_data ? d_addr : f_addr;
                r_wr        <= w_grant_data && d_wr;
                r_byte      <= w_grant_data && d_byte;
                r_first     <= 1'b1;
                if (!w_grant_data) begin
                    r_wdata <= 16'h0000;
                end else if (d_byte) begin
                    r_wdata <= {d_wdata[7:0], d_wdata[7:0]};
                end else begin
                    r_wdata <= d_wdata;
                end
            end else if (r_state == ACCESS) begin
                r_first <= 1'b0;
            end
            if (w_finish) begin
                r_err <= w_misaligned;
                // stores leave the load result untouched
                if (!r_is_data) begin
                    r_f_data <= w_load_data;
                end else if (!r_wr) begin
                    r_d_rdata <= w_load_data;
                end
            end
        end
    end

    assign f_data  = r_f_data;
    assign d_rdata = r_d_rdata;

endmodule
